mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-grant arbiter between the instruction fetch path and the load/store buffer, placed in front of the byte-serial memory controller. Selects one requester at a time and holds the controller's request port until the transaction completes. Routes the result back as a one-cycle ready pulse to the requester. Provides load priority with a starvation bound for fetch, gates I/O accesses while the UART buffer is full, and discards speculative results on flush.

## Interface
- STARVE_LIMIT, 4: consecutive LSB grants allowed while fetch waits; range 1..15
- IO_ADDR0, 32'h0003_0000: first I/O address subject to buffer-full gating
- IO_ADDR1, 32'h0003_0004: second I/O address subject to buffer-full gating
- clk_in  in  1  system clock
- rst_n_in  in  1  reset, asynchronous assert, active-low
- rdy_in  in  1  global ready; low freezes all state and outputs
- flush_in  in  1  mispredict flush, one-cycle pulse
- io_buffer_full  in  1  UART output buffer full
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  32  fetch address
- if_ready  out  1  fetch done pulse
- if_data  out  32  fetched instruction, valid with if_ready
- lsb_req  in  1  load/store request, level, held until lsb_ready
- lsb_addr  in  32  access address
- lsb_wdata  in  32  store data
- lsb_op  in  4  [1:0] width 0=byte/1=half/2=word, [2] unsigned, [3] store
- lsb_ready  out  1  load/store done pulse
- lsb_rdata  out  32  extended load data, valid with lsb_ready
- mc_req  out  1  request to memory controller, level, held until mc_done
- mc_addr  out  32  granted address
- mc_wdata  out  32  granted store data (0 for fetch)
- mc_op  out  4  granted op (4'b0010 for fetch: word, signed, load)
- mc_done  in  1  controller completion pulse
- mc_rdata  in  32  controller result, valid with mc_done

## Operation
- States: IDLE, FETCH, LSB, DRAIN.
- LSB eligibility: lsb_req && !lsb_ready && !(io_buffer_full && lsb_addr ∈ {IO_ADDR0, IO_ADDR1}).
- Fetch eligibility: if_req && !if_ready && !flush_in.
- IDLE grant rule:
  - LSB eligible, and either fetch is not eligible or starve_cnt < STARVE_LIMIT → LSB; starve_cnt increments if fetch is eligible, otherwise clears.
  - Otherwise fetch eligible → FETCH; starve_cnt clears.
  - On a grant, register the mc_* outputs and raise mc_req.
- FETCH/LSB:
  - Hold mc_* stable until mc_done.
  - On mc_done, drop mc_req and go to IDLE.
  - Pulse the owner's ready and latch mc_rdata into if_data or lsb_rdata.
- Flush:
  - In FETCH, or in LSB with a load, flush_in → DRAIN.
  - DRAIN holds mc_req until mc_done, discards the data with no ready pulse, then goes to IDLE.
  - A store in LSB is not affected by flush and completes normally with lsb_ready.
  - A flush and mc_done in the same cycle discard the result.
- A requester whose ready is high is not grantable that cycle, so a request is never served twice.
- Reset values: every output 0, state IDLE, starve_cnt 0. Reset mid-transaction abandons it with no pulse.
- rdy_in low: nothing changes, including starve_cnt. mc_done or flush_in arriving while rdy_in is low are ignored.

## Timing
- Request sampled at edge t → mc_req high after edge t.
- mc_done high in cycle d → ready pulse and data visible in cycle d+1, mc_req low in d+1.
- Next grant is issued at the edge ending cycle d+1, so mc_req is low for at least one cycle between transactions.
- Ready pulses last exactly one cycle. if_data and lsb_rdata hold their values until the next pulse.
- Both requests eligible with starve_cnt == STARVE_LIMIT → fetch is granted. Worst-case fetch wait is STARVE_LIMIT LSB transactions.
- A blocked I/O store does not block fetch. It is granted in the first IDLE cycle after io_buffer_full falls.

## Structure
- Shared constants package: state encoding, lsb_op field positions, fetch op constant 4'b0010, default I/O addresses.
- One natural sub-module, mem_arb_pick: combinational eligibility and grant selection, inputs req/ready/io/starve_cnt, output one-hot grant. Everything else stays in mem_arbiter.

## Test plan
- Fetch only: if_req, if_addr=0x100; mc_done in cycle 5 with mc_rdata=0x00A00093 → if_ready pulse in cycle 6 with if_data=0x00A00093; mc_op=4'b0010.
- Simultaneous requests, STARVE_LIMIT=4: LSB request held and re-raised continuously → 4 LSB grants, then a fetch grant; starve_cnt=0 afterwards.
- I/O gating: store to 0x30000 with io_buffer_full=1 plus if_req → fetch granted first; io_buffer_full falls → store granted; mc_wdata=lsb_wdata.
- Flush during fetch: flush_in two cycles after the grant → no if_ready; mc_req held until mc_done; state IDLE the next cycle; a pending if_req is granted afterwards.
- Flush during store: lsb_op[3]=1 with flush_in mid-transaction → lsb_ready still pulses on completion.
- rdy_in low over mc_done for 3 cycles, then asynchronous reset mid-transaction → no state or output change while rdy_in is low; after reset all outputs 0 and state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, op-field positions and default addresses
// for the fetch / load-store arbiter in front of the memory controller.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LSB   = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;
   localparam int GNT_FETCH = 0;
   localparam int GNT_LSB   = 1;
   localparam int OP_STORE  = 3;
   localparam logic [3:0]  FETCH_OP         = 4'b0010;
   localparam logic [31:0] IO_ADDR0_DEFAULT = 32'h0003_0000;
   localparam logic [31:0] IO_ADDR1_DEFAULT = 32'h0003_0004;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational eligibility and one-hot grant selection,
// load priority bounded by the fetch starvation counter.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int          STARVE_LIMIT = 4,
   parameter logic [31:0] IO_ADDR0     = IO_ADDR0_DEFAULT,
   parameter logic [31:0] IO_ADDR1     = IO_ADDR1_DEFAULT
) (
   input  logic        if_req_i,
   input  logic        if_ready_i,
   input  logic        flush_i,
   input  logic        lsb_req_i,
   input  logic        lsb_ready_i,
   input  logic [31:0] lsb_addr_i,
   input  logic        io_full_i,
   input  logic [3:0]  starve_cnt_i,
   output logic [1:0]  grant_o,
   output logic        fetch_wait_o
);
   logic io_hit;
   logic lsb_ok;
   assign io_hit       = (lsb_addr_i == IO_ADDR0) || (lsb_addr_i == IO_ADDR1);
   assign lsb_ok       = lsb_req_i && !lsb_ready_i && !(io_full_i && io_hit);
   assign fetch_wait_o = if_req_i && !if_ready_i && !flush_i;
   assign grant_o[GNT_LSB]   = lsb_ok && (!fetch_wait_o || starve_cnt_i < 4'(STARVE_LIMIT));
   assign grant_o[GNT_FETCH] = fetch_wait_o && !grant_o[GNT_LSB];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-grant arbiter between instruction fetch and the load/store
// buffer, holding the memory controller port until completion and routing results back.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int          STARVE_LIMIT = 4,
   parameter logic [31:0] IO_ADDR0     = IO_ADDR0_DEFAULT,
   parameter logic [31:0] IO_ADDR1     = IO_ADDR1_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        flush_in,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_data,
   input  logic        lsb_req,
   input  logic [31:0] lsb_addr,
   input  logic [31:0] lsb_wdata,
   input  logic [3:0]  lsb_op,
   output logic        lsb_ready,
   output logic [31:0] lsb_rdata,
   output logic        mc_req,
   output logic [31:0] mc_addr,
   output logic [31:0] mc_wdata,
   output logic [3:0]  mc_op,
   input  logic        mc_done,
   input  logic [31:0] mc_rdata
);
   arb_state_e  state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        mc_req_q, mc_req_d;
   logic [31:0] mc_addr_q, mc_addr_d;
   logic [31:0] mc_wdata_q, mc_wdata_d;
   logic [3:0]  mc_op_q, mc_op_d;
   logic        if_ready_q, if_ready_d;
   logic [31:0] if_data_q, if_data_d;
   logic        lsb_ready_q, lsb_ready_d;
   logic [31:0] lsb_rdata_q, lsb_rdata_d;
   logic [1:0]  grant;
   logic        fetch_wait;
   logic        granting;
   logic        kill;

   mem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .IO_ADDR0    (IO_ADDR0),
      .IO_ADDR1    (IO_ADDR1)
   ) u_pick (
      .if_req_i    (if_req),
      .if_ready_i  (if_ready_q),
      .flush_i     (flush_in),
      .lsb_req_i   (lsb_req),
      .lsb_ready_i (lsb_ready_q),
      .lsb_addr_i  (lsb_addr),
      .io_full_i   (io_buffer_full),
      .starve_cnt_i(starve_q),
      .grant_o     (grant),
      .fetch_wait_o(fetch_wait)
   );

   assign granting = (state_q == ST_IDLE) && |grant;
   // Flush discards fetches and loads; stores already committed run to completion.
   assign kill = flush_in && (state_q == ST_FETCH || (state_q == ST_LSB && !mc_op_q[OP_STORE]));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_IDLE;
         starve_q    <= '0;
         mc_req_q    <= 1'b0;
         mc_addr_q   <= '0;
         mc_wdata_q  <= '0;
         mc_op_q     <= '0;
         if_ready_q  <= 1'b0;
         if_data_q   <= '0;
         lsb_ready_q <= 1'b0;
         lsb_rdata_q <= '0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mc_req_q    <= mc_req_d;
         mc_addr_q   <= mc_addr_d;
         mc_wdata_q  <= mc_wdata_d;
         mc_op_q     <= mc_op_d;
         if_ready_q  <= if_ready_d;
         if_data_q   <= if_data_d;
         lsb_ready_q <= lsb_ready_d;
         lsb_rdata_q <= lsb_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:         state_d = grant[GNT_LSB] ? ST_LSB : grant[GNT_FETCH] ? ST_FETCH : ST_IDLE;
         ST_FETCH, ST_LSB: state_d = mc_done ? ST_IDLE : kill ? ST_DRAIN : state_q;
         default:         state_d = mc_done ? ST_IDLE : ST_DRAIN;
      endcase
   end

   always_comb begin
      mc_req_d    = (state_q == ST_IDLE) ? |grant : !mc_done;
      mc_addr_d   = granting ? (grant[GNT_LSB] ? lsb_addr : if_addr) : mc_addr_q;
      mc_wdata_d  = granting ? (grant[GNT_LSB] ? lsb_wdata : '0) : mc_wdata_q;
      mc_op_d     = granting ? (grant[GNT_LSB] ? lsb_op : FETCH_OP) : mc_op_q;
      if_ready_d  = (state_q == ST_FETCH) && mc_done && !kill;
      if_data_d   = if_ready_d ? mc_rdata : if_data_q;
      lsb_ready_d = (state_q == ST_LSB) && mc_done && !kill;
      lsb_rdata_d = lsb_ready_d ? mc_rdata : lsb_rdata_q;
      starve_d    = granting ? ((grant[GNT_LSB] && fetch_wait) ? starve_q + 4'd1 : '0) : starve_q;
   end

   assign mc_req    = mc_req_q;
   assign mc_addr   = mc_addr_q;
   assign mc_wdata  = mc_wdata_q;
   assign mc_op     = mc_op_q;
   assign if_ready  = if_ready_q;
   assign if_data   = if_data_q;
   assign lsb_ready = lsb_ready_q;
   assign lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus a randomized grant-order check against a
// request-level priority model for mem_arbiter.
module tb_mem_arbiter;
   localparam int          LIMIT = 4;
   localparam logic [31:0] IO0   = 32'h0003_0000;
   localparam logic [31:0] IO1   = 32'h0003_0004;
   localparam logic [3:0]  FOP   = 4'b0010;

   logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0, io_buffer_full = 1'b0;
   logic        if_req = 1'b0, lsb_req = 1'b0, mc_done = 1'b0;
   logic [31:0] if_addr = '0, lsb_addr = '0, lsb_wdata = '0, mc_rdata = '0;
   logic [3:0]  lsb_op = '0;
   logic        if_ready, lsb_ready, mc_req;
   logic [31:0] if_data, lsb_rdata, mc_addr, mc_wdata;
   logic [3:0]  mc_op;
   int          n_cmp = 0, n_bad = 0;

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .IO_ADDR0(IO0), .IO_ADDR1(IO1)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .io_buffer_full(io_buffer_full), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_data(if_data), .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
      .lsb_op(lsb_op), .lsb_ready(lsb_ready), .lsb_rdata(lsb_rdata), .mc_req(mc_req),
      .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_op(mc_op), .mc_done(mc_done), .mc_rdata(mc_rdata)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Acts as the memory controller: holds off lat cycles, pulses mc_done, returns
   // what the arbiter shows in the cycle after completion.
   task automatic finish_txn(input int lat, input logic [31:0] rd, output bit stable,
                             output logic ifr, output logic lsr, output logic req_after,
                             output logic [31:0] ifd, output logic [31:0] lsd);
      logic [31:0] a, w;
      logic [3:0]  o;
      a = mc_addr; w = mc_wdata; o = mc_op; stable = 1'b1;
      for (int i = 0; i < lat; i++) begin
         tick();
         stable &= (mc_req === 1'b1) && (mc_addr === a) && (mc_wdata === w) && (mc_op === o);
      end
      mc_done = 1'b1; mc_rdata = rd;
      tick();
      mc_done = 1'b0; mc_rdata = $urandom;
      ifr = if_ready; lsr = lsb_ready; req_after = mc_req; ifd = if_data; lsd = lsb_rdata;
   endtask

   task automatic test_reset();
      tick(); tick();
      n_cmp++; if ({mc_req, if_ready, lsb_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {mc_req, if_ready, lsb_ready}); end
      n_cmp++; if ({mc_addr, mc_wdata, mc_op} !== '0) begin n_bad++; $display("FAIL reset_mc: got %h %h %h want 0", mc_addr, mc_wdata, mc_op); end
      n_cmp++; if ({if_data, lsb_rdata} !== '0) begin n_bad++; $display("FAIL reset_data: got %h %h want 0", if_data, lsb_rdata); end
      rst_n_in = 1'b1;
      tick();
   endtask

   task automatic test_fetch_only();
      bit st; logic ifr, lsr, ra; logic [31:0] ifd, lsd;
      if_addr = 32'h100; if_req = 1'b1;
      tick();
      n_cmp++; if ({mc_req, mc_addr, mc_op, mc_wdata} !== {1'b1, 32'h100, FOP, 32'h0}) begin n_bad++; $display("FAIL fetch_grant: got %b %h %h %h want 1 00000100 2 0", mc_req, mc_addr, mc_op, mc_wdata); end
      finish_txn(3, 32'h00A0_0093, st, ifr, lsr, ra, ifd, lsd);
      if_req = 1'b0;
      n_cmp++; if (!st) begin n_bad++; $display("FAIL fetch_hold: got unstable want stable"); end
      n_cmp++; if ({ifr, lsr, ra} !== 3'b100) begin n_bad++; $display("FAIL fetch_pulse: got %b want 100", {ifr, lsr, ra}); end
      n_cmp++; if (ifd !== 32'h00A0_0093) begin n_bad++; $display("FAIL fetch_data: got %h want 00a00093", ifd); end
      tick();
      n_cmp++; if ({if_ready, mc_req, if_data} !== {2'b00, 32'h00A0_0093}) begin n_bad++; $display("FAIL fetch_after: got %b %b %h want 0 0 00a00093", if_ready, mc_req, if_data); end
      tick();
   endtask

   task automatic test_io_gate();
      bit st; logic ifr, lsr, ra; logic [31:0] ifd, lsd;
      io_buffer_full = 1'b1; lsb_addr = IO0; lsb_op = 4'b1000; lsb_wdata = 32'h41; lsb_req = 1'b1;
      if_addr = 32'h400; if_req = 1'b1;
      tick();
      n_cmp++; if ({mc_req, mc_addr} !== {1'b1, 32'h400}) begin n_bad++; $display("FAIL io_fetch_first: got %b %h want 1 00000400", mc_req, mc_addr); end
      finish_txn(1, 32'h1234, st, ifr, lsr, ra, ifd, lsd);
      if_req = 1'b0;
      n_cmp++; if ({ifr, lsr} !== 2'b10) begin n_bad++; $display("FAIL io_fetch_done: got %b want 10", {ifr, lsr}); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (mc_req !== 1'b0) begin n_bad++; $display("FAIL io_blocked: got %b want 0", mc_req); end
      end
      io_buffer_full = 1'b0;
      tick();
      n_cmp++; if ({mc_req, mc_addr, mc_wdata, mc_op} !== {1'b1, IO0, 32'h41, 4'b1000}) begin n_bad++; $display("FAIL io_store_grant: got %b %h %h %h want 1 %h 41 8", mc_req, mc_addr, mc_wdata, mc_op, IO0); end
      finish_txn(2, 32'h0, st, ifr, lsr, ra, ifd, lsd);
      lsb_req = 1'b0;
      n_cmp++; if ({ifr, lsr, ra} !== 3'b010) begin n_bad++; $display("FAIL io_store_done: got %b want 010", {ifr, lsr, ra}); end
      tick(); tick();
   endtask

   task automatic test_flush_fetch();
      bit st; logic ifr, lsr, ra; logic [31:0] ifd, lsd, rd;
      if_addr = 32'h300; if_req = 1'b1;
      tick();
      n_cmp++; if ({mc_req, mc_addr} !== {1'b1, 32'h300}) begin n_bad++; $display("FAIL ff_grant: got %b %h want 1 00000300", mc_req, mc_addr); end
      tick(); tick();
      flush_in = 1'b1; if_addr = 32'h304;
      tick();
      flush_in = 1'b0;
      n_cmp++; if (mc_req !== 1'b1) begin n_bad++; $display("FAIL ff_drain_hold: got %b want 1", mc_req); end
      finish_txn(2, 32'hBAD0_BAD0, st, ifr, lsr, ra, ifd, lsd);
      n_cmp++; if ({st, ifr, lsr, ra} !== 4'b1000) begin n_bad++; $display("FAIL ff_discard: got %b want 1000", {st, ifr, lsr, ra}); end
      tick();
      n_cmp++; if ({mc_req, mc_addr} !== {1'b1, 32'h304}) begin n_bad++; $display("FAIL ff_refetch: got %b %h want 1 00000304", mc_req, mc_addr); end
      rd = $urandom;
      finish_txn(1, rd, st, ifr, lsr, ra, ifd, lsd);
      if_req = 1'b0;
      n_cmp++; if ({ifr, ifd} !== {1'b1, rd}) begin n_bad++; $display("FAIL ff_refetch_done: got %b %h want 1 %h", ifr, ifd, rd); end
      tick(); tick();
   endtask

   task automatic test_flush_store();
      bit st; logic ifr, lsr, ra; logic [31:0] ifd, lsd, rd, held;
      lsb_addr = 32'h2000; lsb_wdata = 32'hCAFE_F00D; lsb_op = 4'b1010; lsb_req = 1'b1;
      tick();
      n_cmp++; if ({mc_req, mc_wdata, mc_op} !== {1'b1, 32'hCAFE_F00D, 4'b1010}) begin n_bad++; $display("FAIL fs_grant: got %b %h %h want 1 cafef00d a", mc_req, mc_wdata, mc_op); end
      tick();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      rd = $urandom;
      finish_txn(1, rd, st, ifr, lsr, ra, ifd, lsd);
      lsb_req = 1'b0;
      held = rd;
      n_cmp++; if ({lsr, ra, lsd} !== {2'b10, rd}) begin n_bad++; $display("FAIL fs_store_completes: got %b %b %h want 1 0 %h", lsr, ra, lsd, rd); end
      tick();
      n_cmp++; if (lsb_ready !== 1'b0) begin n_bad++; $display("FAIL fs_one_cycle: got %b want 0", lsb_ready); end
      // load whose completion coincides with a flush: result dropped, request re-served
      lsb_addr = 32'h2100; lsb_op = 4'b0110; lsb_req = 1'b1;
      tick();
      flush_in = 1'b1;
      finish_txn(0, 32'h5555_5555, st, ifr, lsr, ra, ifd, lsd);
      flush_in = 1'b0;
      n_cmp++; if ({lsr, ra, lsd} !== {2'b00, held}) begin n_bad++; $display("FAIL fs_same_cycle: got %b %b %h want 0 0 %h", lsr, ra, lsd, held); end
      tick();
      n_cmp++; if ({mc_req, mc_addr} !== {1'b1, 32'h2100}) begin n_bad++; $display("FAIL fs_reissue: got %b %h want 1 00002100", mc_req, mc_addr); end
      rd = $urandom;
      finish_txn(1, rd, st, ifr, lsr, ra, ifd, lsd);
      lsb_req = 1'b0;
      n_cmp++; if ({lsr, lsd} !== {1'b1, rd}) begin n_bad++; $display("FAIL fs_reissue_done: got %b %h want 1 %h", lsr, lsd, rd); end
      tick(); tick();
   endtask

   // Flushed loads leave no ready pulse, so the load stays eligible each time the
   // arbiter idles while fetch waits; only the starvation bound lets fetch through.
   task automatic test_starvation();
      bit st, gotf; int nl; logic ifr, lsr, ra; logic [31:0] ifd, lsd;
      if_addr = 32'h200; if_req = 1'b1;
      lsb_addr = 32'h1000; lsb_op = 4'b0000; lsb_req = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
         nl = 0; gotf = 1'b0;
         for (int g = 0; g < 10 && !gotf; g++) begin
            tick();
            n_cmp++; if (mc_req !== 1'b1) begin n_bad++; $display("FAIL starve_grant: got %b want 1", mc_req); end
            if (mc_addr === if_addr) begin
               gotf = 1'b1;
               finish_txn(1, 32'h13, st, ifr, lsr, ra, ifd, lsd);
               if_addr = if_addr + 32'd4;
            end else begin
               nl++;
               tick();
               flush_in = 1'b1;
               tick();
               flush_in = 1'b0;
               finish_txn(1, 32'h77, st, ifr, lsr, ra, ifd, lsd);
               n_cmp++; if ({lsr, ra} !== 2'b00) begin n_bad++; $display("FAIL starve_flushed: got %b want 00", {lsr, ra}); end
            end
         end
         n_cmp++; if (nl !== (ph == 0 ? LIMIT : LIMIT + 1)) begin n_bad++; $display("FAIL starve_count_ph%0d: got %0d want %0d", ph, nl, ph == 0 ? LIMIT : LIMIT + 1); end
      end
      if_req = 1'b0; lsb_req = 1'b0;
      tick(); tick();
   endtask

   // Reference: per request set, the winner follows load priority unless fetch has
   // already waited through LIMIT load grants; blocked I/O waits for the buffer.
   task automatic test_random_mix();
      int starve, k, lat;
      bit pf, pl, le, fe, wl, st, is_io;
      logic ifr, lsr, ra;
      logic [31:0] fa, la, lw, ifd, lsd, rd;
      logic [3:0] lo;
      starve = 0;
      for (int r = 0; r < 30; r++) begin
         pf = 1'($urandom_range(0, 1)); pl = 1'($urandom_range(0, 1));
         if (!pf && !pl) pl = 1'b1;
         fa = $urandom & 32'hFFFF_FFFC;
         la = ($urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) ? IO0 : IO1) : $urandom;
         lo = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         lw = $urandom;
         is_io = (la == IO0) || (la == IO1);
         io_buffer_full = is_io && 1'($urandom_range(0, 1));
         if_req = pf; if_addr = fa; lsb_req = pl; lsb_addr = la; lsb_op = lo; lsb_wdata = lw;
         while (pf || pl) begin
            le = pl && !(io_buffer_full && is_io);
            fe = pf;
            if (!le && !fe) begin
               k = $urandom_range(1, 3);
               for (int i = 0; i < k; i++) begin
                  tick();
                  n_cmp++; if (mc_req !== 1'b0) begin n_bad++; $display("FAIL rand_io_blocked r%0d: got %b want 0", r, mc_req); end
               end
               io_buffer_full = 1'b0;
               continue;
            end
            wl = le && (!fe || starve < LIMIT);
            starve = (wl && fe) ? starve + 1 : 0;
            tick();
            n_cmp++;
            if ({mc_req, mc_addr, mc_op, mc_wdata} !== {1'b1, wl ? la : fa, wl ? lo : FOP, wl ? lw : 32'h0}) begin
               n_bad++;
               $display("FAIL rand_grant r%0d: got %b %h %h %h want 1 %h %h %h", r, mc_req, mc_addr, mc_op, mc_wdata, wl ? la : fa, wl ? lo : FOP, wl ? lw : 32'h0);
            end
            rd = $urandom; lat = $urandom_range(0, 3);
            finish_txn(lat, rd, st, ifr, lsr, ra, ifd, lsd);
            n_cmp++;
            if ({st, ifr, lsr, ra, wl ? lsd : ifd} !== {1'b1, !wl, wl, 1'b0, rd}) begin
               n_bad++;
               $display("FAIL rand_done r%0d: got %b%b%b%b %h want 1%b%b0 %h", r, st, ifr, lsr, ra, wl ? lsd : ifd, !wl, wl, rd);
            end
            if (wl) begin pl = 1'b0; lsb_req = 1'b0; end
            else begin pf = 1'b0; if_req = 1'b0; end
         end
         tick();
         n_cmp++; if ({if_ready, lsb_ready, mc_req} !== 3'b000) begin n_bad++; $display("FAIL rand_quiet r%0d: got %b want 000", r, {if_ready, lsb_ready, mc_req}); end
      end
      io_buffer_full = 1'b0;
   endtask

   task automatic test_rdy_reset();
      if_addr = 32'h500; if_req = 1'b1;
      tick();
      rdy_in = 1'b0; mc_done = 1'b1; mc_rdata = 32'hDEAD_BEEF; flush_in = 1'b1; if_addr = 32'h504;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if ({mc_req, if_ready, lsb_ready, mc_addr} !== {3'b100, 32'h500}) begin n_bad++; $display("FAIL rdy_freeze: got %b %h want 100 00000500", {mc_req, if_ready, lsb_ready}, mc_addr); end
      end
      rdy_in = 1'b1; mc_done = 1'b0; flush_in = 1'b0;
      tick();
      n_cmp++; if ({mc_req, if_ready, mc_addr} !== {2'b10, 32'h500}) begin n_bad++; $display("FAIL rdy_resume: got %b %b %h want 1 0 00000500", mc_req, if_ready, mc_addr); end
      #2 rst_n_in = 1'b0;
      #1;
      n_cmp++; if ({mc_req, if_ready, lsb_ready, mc_addr, mc_wdata, mc_op, if_data, lsb_rdata} !== '0) begin n_bad++; $display("FAIL async_reset: got %b %h %h %h want all 0", {mc_req, if_ready, lsb_ready}, mc_addr, if_data, lsb_rdata); end
      if_req = 1'b0;
      tick();
      rst_n_in = 1'b1;
      tick(); tick();
      n_cmp++; if ({mc_req, if_ready, lsb_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_abandon: got %b want 000", {mc_req, if_ready, lsb_ready}); end
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_io_gate();
      test_flush_fetch();
      test_flush_store();
      test_starvation();
      test_random_mix();
      test_rdy_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
